// File: rtl/hc_mmio_master.sv
// hc_mmio_master -- MMIO initiator for the HardCloud CSR space.
//
// Takes one command at a time over a valid/ready handshake. It turns each
// command into a CCI-P MMIO read or write request on a c0 Rx channel. For a
// read, it waits for the matching response on the c2 Tx channel and then
// returns a single response beat. A timeout ends any read whose response
// never arrives.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_write         1 = MMIO write, 0 = MMIO read
//   cmd_address       DWORD address
//   cmd_length        0 = 4 B, 1 = 8 B (8 B needs an even address)
//   cmd_data          write data
//   mmio_rx           generated MMIO request channel (c0 Rx)
//   mmio_tx           MMIO read response channel (c2 Tx)
//   rsp_valid/ready   response handshake; outputs held until accepted
//   rsp_status        00 OK, 01 timeout, 10 bad command
//   rsp_write         cmd_write of the completed command
//   rsp_data          read data (0 for writes and errors)
//   stray_seen        sticky flag for unmatched read responses

// Subset of the CCI-P interface package covering the MMIO fields used here.
package ccip_if_pkg;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_clData        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;
endpackage

module hc_mmio_master
  import ccip_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [15:0]    cmd_address,
  input  logic [1:0]     cmd_length,
  input  logic [63:0]    cmd_data,
  output t_if_ccip_c0_Rx mmio_rx,
  input  t_if_ccip_c2_Tx mmio_tx,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_status,
  output logic           rsp_write,
  output logic [63:0]    rsp_data,
  output logic           stray_seen
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TMO = 2'b01;
  localparam logic [1:0] ST_BAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t         state_q;
  logic [8:0]     tid_cnt_q;
  logic [8:0]     tid_cnt_d;
  logic [8:0]     iss_tid_q;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  t_if_ccip_c0_Rx mmio_rx_q;
  t_if_ccip_c0_Rx req_d;
  logic           cmd_ready_q;
  logic           rsp_valid_q;
  logic [1:0]     rsp_status_q;
  logic           rsp_write_q;
  logic [63:0]    rsp_data_q;
  logic           stray_q;
  logic           cmd_bad;
  logic           rd_hit;

  always_comb begin
    // Length codes 2/3 do not exist; an 8 B access must be QWORD aligned.
    cmd_bad   = cmd_length[1] | (cmd_length[0] & cmd_address[0]);
    rd_hit    = (state_q == WAIT_RD) && mmio_tx.mmioRdValid && (mmio_tx.hdr.tid == iss_tid_q);
    tid_cnt_d = tid_cnt_q + 9'd1;
    tmo_d     = tmo_q + TMO_W'(1);

    req_d                 = '0;
    req_d.mmioWrValid     = cmd_write;
    req_d.mmioRdValid     = !cmd_write;
    req_d.hdr.address     = cmd_address;
    req_d.hdr.length      = cmd_length;
    req_d.hdr.tid         = tid_cnt_q;
    req_d.data            = t_ccip_clData'(cmd_data);
  end

  // The request is registered at acceptance, so it is visible exactly during
  // the ISSUE cycle. The default below drops it again one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tid_cnt_q    <= '0;
      tmo_q        <= '0;
      mmio_rx_q    <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_write_q  <= 1'b0;
      rsp_data_q   <= '0;
      stray_q      <= 1'b0;
    end else begin
      mmio_rx_q <= '0;

      // Any read response that does not complete the outstanding read is
      // stray. This includes late responses that arrive after a timeout.
      if (mmio_tx.mmioRdValid && !rd_hit) stray_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            rsp_write_q <= cmd_write;
            rsp_data_q  <= '0;
            if (cmd_bad) begin
              state_q      <= RESP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= ST_BAD;
            end else begin
              state_q   <= ISSUE;
              mmio_rx_q <= req_d;
            end
          end
        end

        ISSUE: begin
          // rsp_write_q already holds the latched command direction.
          if (rsp_write_q) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_OK;
          end else begin
            state_q   <= WAIT_RD;
            tid_cnt_q <= tid_cnt_d;
            tmo_q     <= '0;
          end
        end

        WAIT_RD: begin
          // A response takes priority over expiry in the same cycle.
          if (rd_hit) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_OK;
            rsp_data_q   <= mmio_tx.data;
          end else if (tmo_q == TMO_LAST) begin
            state_q      <= RESP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_TMO;
            rsp_data_q   <= '0;
          end else begin
            tmo_q <= tmo_d;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag of the outstanding read. It is only meaningful in WAIT_RD, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cmd_valid && cmd_ready_q) iss_tid_q <= tid_cnt_q;
  end

  assign cmd_ready  = cmd_ready_q;
  assign mmio_rx    = mmio_rx_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_data   = rsp_data_q;
  assign stray_seen = stray_q;

endmodule
